ldpc_llr_loader: RTL
====================

Name: ldpc_llr_loader

Overview:
- Upstream write-side feeder for the LDPC super RAM.
- Accepts a serial stream of signed channel LLRs, one codeword per frame, and saturates each LLR to WIDTH bits.
- Scatters each LLR into the flat per-lane data/address/valid write buses that fill every branch RAM of the owning bank.
- Signals frame completion and framing errors to the decoder controller.

Parameters:
- IN_WIDTH, 10, input LLR width, signed two's complement.
- WIDTH, 8, stored LLR width, signed; must satisfy WIDTH <= IN_WIDTH.
- NUM_RAMS, 12, number of banks (circulant columns).
- EXPANSION_FACTOR, 96, words per bank (Z).
- NUM_BRANCHES, 8, lanes per bank on the write bus.
- Derived: ADDR_W = $clog2(EXPANSION_FACTOR); NUM_LANES = NUM_BRANCHES*NUM_RAMS; FRAME_LEN = NUM_RAMS*EXPANSION_FACTOR.

Ports:
- i_clock  in  1  sole clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  arms loader for one frame; honoured only in IDLE.
- i_abort  in  1  returns to IDLE immediately, no done/err pulse.
- i_llr  in  IN_WIDTH  input LLR.
- i_llr_valid  in  1  input valid.
- i_llr_last  in  1  marks final LLR of frame.
- o_llr_ready  out  1  input ready.
- o_wr_data  out  NUM_LANES*WIDTH  lane l at bits [(l+1)*WIDTH-1 : l*WIDTH].
- o_wr_addr  out  NUM_LANES*ADDR_W  lane l at bits [(l+1)*ADDR_W-1 : l*ADDR_W].
- o_wr_valid  out  NUM_LANES  per-lane write strobe.
- o_busy  out  1  high in LOAD.
- o_frame_done  out  1  one-cycle pulse.
- o_frame_err  out  1  one-cycle pulse.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State IDLE; counters at 0.
  - All outputs 0, including o_wr_data/o_wr_addr.
- States:
  - IDLE: o_llr_ready = 0. i_start -> LOAD with bank_cnt = 0, addr_cnt = 0.
  - LOAD: o_llr_ready = 1, o_busy = 1. Each accepted beat (valid & ready) writes one LLR.
    - Normal beat: addr_cnt++. On addr_cnt = Z-1, wrap to 0 and bank_cnt++.
    - Final beat (bank_cnt = NUM_RAMS-1, addr_cnt = Z-1) with i_llr_last = 1: -> IDLE, o_frame_done pulses on the cycle after the beat.
    - Final beat without i_llr_last: still written; -> IDLE, o_frame_err pulses instead of o_frame_done.
    - i_llr_last on any earlier beat: that beat is written; -> IDLE, o_frame_err pulses.
    - Only one of o_frame_done / o_frame_err ever pulses per frame.
- Index mapping: LLR n maps to bank = n / Z, addr = n mod Z (column-major by circulant).
- Write bus (registered, 1-cycle latency from the accepted beat):
  - For the beat's bank b, lanes k*NUM_RAMS + b for all k in 0..NUM_BRANCHES-1 assert o_wr_valid. All other lanes are 0.
  - Data and address are broadcast to every lane; only the valid lanes carry meaning.
  - With no accepted beat, o_wr_valid = 0 and data/address hold their last value.
- Saturation: clip the signed input to [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1] (symmetric).
  - -2^(WIDTH-1) is never produced; for WIDTH = 8, -128 maps to -127.
- Input handshake: i_llr_valid while not ready is ignored, not stored. The input has no buffering; ready is purely state-based.
- i_start while LOAD is ignored.
- i_abort has priority over everything:
  - Next cycle: IDLE, counters cleared, o_wr_valid = 0.
  - A beat accepted in the same cycle as i_abort is dropped.
- Async reset mid-frame: immediate IDLE; outputs forced to 0.

Decomposition:
- Package ldpc_loader_pkg holds:
  - enum state_t {IDLE, LOAD}.
  - Function sat_llr(in, IN_WIDTH, WIDTH).
  - Function lane_index(branch, bank, NUM_RAMS).
- One natural sub-module: ldpc_llr_saturate (combinational IN_WIDTH -> WIDTH clip). The counters and FSM stay in the top module.

Test Plan:
- Full frame, defaults: i_start, then 1152 LLRs with value n mod 64, last on beat 1151.
  - Beat 0: lanes 0,12,...,84 valid, addr 0.
  - Beat 96: lanes 1,13,...,85 valid, addr 0.
  - Beat 1151: lanes 11,...,95 valid, addr 95.
  - o_frame_done pulses once, the cycle after beat 1151.
- Saturation: inputs 300, -300, -128, 127, -1 -> o_wr_data 127, -127, -127, 127, -1.
- Early last: i_llr_last on beat 500 -> beat 500 written (bank 5, addr 20); o_frame_err pulses; o_llr_ready = 0 next cycle.
- Missing last: 1152 beats with no last -> all written; o_frame_err pulses, o_frame_done stays 0.
- Backpressure/gaps: random i_llr_valid gaps in LOAD, i_llr_valid held high in IDLE -> no writes in IDLE; address sequence in LOAD contiguous, unaffected by gaps.
- Abort and reset mid-frame:
  - i_abort at beat 200 -> no write for beat 200; no done/err pulse.
  - A new i_start afterwards restarts at bank 0, addr 0.
  - i_reset_n low mid-frame -> outputs 0 within the same cycle.

Source files
------------

// File: rtl/ldpc_loader_pkg.sv
// Shared types and helpers for the LDPC LLR write-side loader.
// Saturation and lane placement used by the loader datapath.
package ldpc_loader_pkg;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    // Symmetric clip: the most negative code is never produced.
    function automatic int sat_llr(
        input int in,
        input int in_width,
        input int width
    );
        int lim;
        lim = (1 << (width - 1)) - 1;
        if (width > in_width) return in;
        if (in > lim) return lim;
        if (in < -lim) return -lim;
        return in;
    endfunction

    function automatic int lane_index(
        input int branch,
        input int bank,
        input int num_rams
    );
        return branch * num_rams + bank;
    endfunction

endpackage

// File: rtl/ldpc_llr_saturate.sv
// Combinational signed clip of an IN_WIDTH LLR down to WIDTH bits.
// Output range is symmetric about zero.
module ldpc_llr_saturate
    import ldpc_loader_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int WIDTH    = 8
) (
    input  logic [IN_WIDTH-1:0] llr_i,
    output logic [WIDTH-1:0]    llr_o
);

    logic signed [IN_WIDTH-1:0] llr_s;

    assign llr_s = $signed(llr_i);
    assign llr_o = WIDTH'(sat_llr(int'(llr_s), IN_WIDTH, WIDTH));

endmodule

// File: rtl/ldpc_llr_loader.sv
// Serial LLR stream to per-lane branch RAM write bus for one LDPC frame.
// LLR n lands in bank n/Z at address n mod Z on every branch of that bank.
module ldpc_llr_loader
    import ldpc_loader_pkg::*;
#(
    parameter int IN_WIDTH         = 10,
    parameter int WIDTH            = 8,
    parameter int NUM_RAMS         = 12,
    parameter int EXPANSION_FACTOR = 96,
    parameter int NUM_BRANCHES     = 8,
    parameter int ADDR_W           = $clog2(EXPANSION_FACTOR),
    parameter int NUM_LANES        = NUM_BRANCHES * NUM_RAMS
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [IN_WIDTH-1:0]         i_llr,
    input  logic                        i_llr_valid,
    input  logic                        i_llr_last,
    output logic                        o_llr_ready,
    output logic [NUM_LANES*WIDTH-1:0]  o_wr_data,
    output logic [NUM_LANES*ADDR_W-1:0] o_wr_addr,
    output logic [NUM_LANES-1:0]        o_wr_valid,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_frame_err
);

    localparam int BANK_W = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(EXPANSION_FACTOR - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_RAMS - 1);
    localparam logic [NUM_LANES-1:0] LANE_ONE = NUM_LANES'(1);

    state_t                      state_q, state_d;
    logic [BANK_W-1:0]           bank_cnt_q, bank_cnt_d;
    logic [ADDR_W-1:0]           addr_cnt_q, addr_cnt_d;
    logic [NUM_LANES*WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [NUM_LANES*ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_LANES-1:0]        wr_valid_q, wr_valid_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic [WIDTH-1:0]     llr_sat;
    logic [NUM_LANES-1:0] lane_mask;
    logic                 last_pos;

    ldpc_llr_saturate #(
        .IN_WIDTH (IN_WIDTH),
        .WIDTH    (WIDTH)
    ) u_sat (
        .llr_i (i_llr),
        .llr_o (llr_sat)
    );

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < NUM_BRANCHES; k++) begin
            lane_mask |= LANE_ONE << lane_index(k, int'(bank_cnt_q), NUM_RAMS);
        end
    end

    assign last_pos = (bank_cnt_q == BANK_LAST) && (addr_cnt_q == ADDR_LAST);

    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        addr_cnt_d = addr_cnt_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        wr_valid_d = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (i_abort) begin
            state_d    = IDLE;
            bank_cnt_d = '0;
            addr_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d    = LOAD;
                        bank_cnt_d = '0;
                        addr_cnt_d = '0;
                    end
                end
                LOAD: begin
                    if (i_llr_valid) begin
                        wr_valid_d = lane_mask;
                        wr_data_d  = {NUM_LANES{llr_sat}};
                        wr_addr_d  = {NUM_LANES{addr_cnt_q}};
                        if (last_pos || i_llr_last) begin
                            state_d    = IDLE;
                            bank_cnt_d = '0;
                            addr_cnt_d = '0;
                            done_d     = last_pos && i_llr_last;
                            err_d      = last_pos != i_llr_last;
                        end else if (addr_cnt_q == ADDR_LAST) begin
                            addr_cnt_d = '0;
                            bank_cnt_d = bank_cnt_q + BANK_W'(1);
                        end else begin
                            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            bank_cnt_q <= '0;
            addr_cnt_q <= '0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_valid_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_valid_q <= wr_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_llr_ready  = (state_q == LOAD);
    assign o_busy       = (state_q == LOAD);
    assign o_wr_data    = wr_data_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;

endmodule
